// File: rtl/usng_pkg.sv
// Shared constants, FSM encoding and helpers for the dual unary stream generator.
package usng_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned FRAME_LEN = 256;
    localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [DATA_W-1:0] LAST_CNT  = DATA_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Van der Corput ordering: mirror the counter bits.
    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/usng_lfsr8.sv
// 8-bit right-shifting Galois LFSR; load and reset both restart at SEED.
module lfsr8
    import usng_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    output logic [DATA_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state <= SEED;
        end else if (en) begin
            state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
        end
    end

endmodule

// File: rtl/usng_dual.sv
// Converts two 8-bit operands into 256-bit unary frames: A in van der Corput
// order, B against a full-period LFSR sequence padded with zero.
module usng_dual
    import usng_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED = 8'h01
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iDataA,
    input  logic [DATA_W-1:0] iDataB,
    output logic              oReady,
    output logic              oA,
    output logic              oB,
    output logic              oValid,
    output logic              oLast
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] reg_a, reg_a_nxt;
    logic [DATA_W-1:0] reg_b, reg_b_nxt;
    logic [DATA_W-1:0] lfsr;
    logic [DATA_W-1:0] rand_a;
    logic [DATA_W-1:0] rand_b;
    logic              running;
    logic              last;
    logic              accept;

    assign running = (state == RUN);
    assign last    = running && (cnt == LAST_CNT);
    assign accept  = iValid && oReady;

    // State and datapath registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            cnt   <= '0;
            reg_a <= '0;
            reg_b <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            reg_a <= reg_a_nxt;
            reg_b <= reg_b_nxt;
        end
    end

    // Next state: a load wins over frame advance, which lets the last bit chain frames
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        reg_a_nxt = reg_a;
        reg_b_nxt = reg_b;
        if (accept) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            reg_a_nxt = iDataA;
            reg_b_nxt = iDataB;
        end else if (running) begin
            cnt_nxt = cnt + DATA_W'(1);
            if (last) begin
                state_nxt = IDLE;
            end
        end
    end

    lfsr8 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (iClk),
        .rst   (iRst),
        .load  (accept),
        .en    (running),
        .state (lfsr)
    );

    // The LFSR never emits zero, so the final slot supplies it to complete the 256 values
    assign rand_a = bit_rev(cnt);
    assign rand_b = (cnt == LAST_CNT) ? '0 : lfsr;

    assign oReady = (state == IDLE) || last;
    assign oValid = running;
    assign oLast  = last;
    assign oA     = running && (reg_a > rand_a);
    assign oB     = running && (reg_b > rand_b);

endmodule

// File: tb/tb_usng_dual.sv
// Self-checking bench for usng_dual: per-cycle behavioural model plus frame-level checks.
module tb_usng_dual;

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic       iValid = 1'b0;
    logic [7:0] iDataA = 8'h00;
    logic [7:0] iDataB = 8'h00;
    logic       oReady, oA, oB, oValid, oLast;

    int n_tests = 0;
    int n_fail  = 0;

    usng_dual #(.SEED(8'h01)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iValid (iValid),
        .iDataA (iDataA),
        .iDataB (iDataB),
        .oReady (oReady),
        .oA     (oA),
        .oB     (oB),
        .oValid (oValid),
        .oLast  (oLast)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    int  seq [256];
    logic m_known = 1'b0;
    logic m_run = 1'b0;
    int  m_k = 0;
    int  m_a = 0;
    int  m_b = 0;

    function automatic int rev8(input int v);
        int r = 0;
        for (int i = 0; i < 8; i++) if (((v >> i) & 1) != 0) r += 1 << (7 - i);
        return r;
    endfunction

    function automatic int rand_b_of(input int k);
        return (k == 255) ? 0 : seq[k];
    endfunction

    initial begin
        int v;
        v = 1;
        for (int k = 0; k < 255; k++) begin
            seq[k] = v;
            v = ((v & 1) != 0) ? ((v >> 1) ^ 8'hB8) : (v >> 1);
        end
        seq[255] = 0;
    end

    always @(posedge iClk) begin
        if (iRst) begin
            m_known = 1'b1;
            m_run = 1'b0; m_k = 0; m_a = 0; m_b = 0;
        end else if (iValid && (!m_run || m_k == 255)) begin
            m_run = 1'b1; m_k = 0; m_a = int'(iDataA); m_b = int'(iDataB);
        end else if (m_run) begin
            if (m_k == 255) m_run = 1'b0;
            else m_k++;
        end
    end

    // ---------------- per-cycle compare and logging ----------------
    int qa[$], qb[$], ql[$];
    int run_len = 0;
    int max_run = 0;

    always @(negedge iClk) begin
        int exp_v, got_v;
        if (m_known) begin
            exp_v = 0;
            if (!m_run || m_k == 255) exp_v += 16;
            if (m_run) begin
                exp_v += 8;
                if (m_k == 255) exp_v += 4;
                if (m_a > rev8(m_k)) exp_v += 2;
                if (m_b > rand_b_of(m_k)) exp_v += 1;
            end
            got_v = {27'd0, oReady, oValid, oLast, oA, oB};
            chk("cycle{ready,valid,last,a,b}", got_v, exp_v);
        end
        if (oValid === 1'b1) begin
            qa.push_back(int'(oA)); qb.push_back(int'(oB)); ql.push_back(int'(oLast));
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    function automatic int sum_a(input int lo, input int hi);
        int s = 0;
        for (int i = lo; i < hi && i < qa.size(); i++) s += qa[i];
        return s;
    endfunction

    function automatic int sum_b(input int lo, input int hi);
        int s = 0;
        for (int i = lo; i < hi && i < qb.size(); i++) s += qb[i];
        return s;
    endfunction

    function automatic int sum_l(input int lo, input int hi);
        int s = 0;
        for (int i = lo; i < hi && i < ql.size(); i++) s += ql[i];
        return s;
    endfunction

    function automatic int q_at(input int which, input int i);
        if (which == 0) return (i < qa.size()) ? qa[i] : -1;
        if (which == 1) return (i < qb.size()) ? qb[i] : -1;
        return (i < ql.size()) ? ql[i] : -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        qa.delete(); qb.delete(); ql.delete();
        max_run = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge iClk);
        while (oReady !== 1'b1 && n < 600) begin
            @(negedge iClk);
            n++;
        end
        if (n >= 600) chk("ready_timeout", 0, 1);
    endtask

    // Returns at the negedge of frame bit 0.
    task automatic load(input logic [7:0] a, input logic [7:0] b);
        wait_ready();
        iValid = 1'b1; iDataA = a; iDataB = b;
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iRst = 1'b1;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        int bitmap [256];
        int distinct;
        int ff_pos;

        // Pin the model against hand-derived values
        #1;
        chk("model_seq0", seq[0], 8'h01);
        chk("model_seq1", seq[1], 8'hB8);
        chk("model_rev1", rev8(1), 8'h80);
        chk("model_rev3", rev8(3), 8'hC0);
        for (int i = 0; i < 256; i++) bitmap[i] = 0;
        for (int k = 0; k < 256; k++) bitmap[rand_b_of(k)] = 1;
        distinct = 0;
        for (int i = 0; i < 256; i++) distinct += bitmap[i];
        chk("model_randb_full_cover", distinct, 256);

        // Reset state
        do_reset();
        chk("rst_ready", int'(oReady), 1);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_oa_ob_last", int'({oA, oB, oLast}), 0);

        // Single frame 0x80 / 0x40
        clear_logs();
        load(8'h80, 8'h40);
        repeat (260) @(negedge iClk);
        chk("f1_len", qa.size(), 256);
        chk("f1_ones_a", sum_a(0, 256), 128);
        chk("f1_ones_b", sum_b(0, 256), 64);
        chk("f1_last_count", sum_l(0, 256), 1);
        chk("f1_last_pos", q_at(2, 255), 1);
        chk("f1_a_bits0_3", q_at(0, 0) * 8 + q_at(0, 1) * 4 + q_at(0, 2) * 2 + q_at(0, 3), 10);
        chk("f1_b_bits0_1", q_at(1, 0) * 2 + q_at(1, 1), 2);

        // Extremes 0x00 / 0xFF: oB drops only where the LFSR reads 0xFF
        clear_logs();
        load(8'h00, 8'hFF);
        repeat (260) @(negedge iClk);
        ff_pos = -1;
        for (int k = 0; k < 256; k++) if (rand_b_of(k) == 8'hFF) ff_pos = k;
        chk("f2_ones_a", sum_a(0, 256), 0);
        chk("f2_ones_b", sum_b(0, 256), 255);
        chk("f2_b_zero_at_ff", q_at(1, ff_pos), 0);

        // Early request ignored at cnt 50, then held into the last bit for back-to-back
        clear_logs();
        load(8'h33, 8'hC5);
        repeat (50) @(negedge iClk);
        iValid = 1'b1; iDataA = 8'h10; iDataB = 8'hF0;
        chk("f3_busy_not_ready", int'(oReady), 0);
        repeat (206) @(negedge iClk);
        iValid = 1'b0;
        repeat (260) @(negedge iClk);
        chk("f3_total_len", qa.size(), 512);
        chk("f3_max_run", max_run, 512);
        chk("f3_first_a", sum_a(0, 256), 8'h33);
        chk("f3_first_b", sum_b(0, 256), 8'hC5);
        chk("f3_second_a", sum_a(256, 512), 16);
        chk("f3_second_b", sum_b(256, 512), 240);
        chk("f3_last_count", sum_l(0, 512), 2);

        // Reset mid-frame at cnt 100
        clear_logs();
        load(8'hFF, 8'hFF);
        repeat (100) @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        chk("f4_after_rst_valid", int'(oValid), 0);
        chk("f4_after_rst_ready", int'(oReady), 1);
        repeat (20) @(negedge iClk);
        chk("f4_bits_before_rst", qa.size(), 101);
        chk("f4_ones_a", sum_a(0, 256), 101);
        clear_logs();
        load(8'h80, 8'h40);
        repeat (5) @(negedge iClk);
        chk("f4_reload_a_bits0_3", q_at(0, 0) * 8 + q_at(0, 1) * 4 + q_at(0, 2) * 2 + q_at(0, 3), 10);
        chk("f4_reload_b_bits0_1", q_at(1, 0) * 2 + q_at(1, 1), 2);
        repeat (260) @(negedge iClk);

        // Randomised frames with noisy iValid; the per-cycle model checks everything
        for (int f = 0; f < 6; f++) begin
            load(8'($urandom), 8'($urandom));
            for (int c = 0; c < 300; c++) begin
                iValid = ($urandom_range(0, 7) == 0);
                iDataA = 8'($urandom);
                iDataB = 8'($urandom);
                @(negedge iClk);
            end
            iValid = 1'b0;
            repeat (260) @(negedge iClk);
        end

        // Randomised single frames with count checks
        for (int f = 0; f < 4; f++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            clear_logs();
            load(8'(a), 8'(b));
            repeat (260) @(negedge iClk);
            chk("rnd_ones_a", sum_a(0, 256), a);
            chk("rnd_ones_b", sum_b(0, 256), b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
